// File: rtl/pc_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq_if
//   Instruction-memory request channel between the fetch sequencer and imem.
//
//   Handshake: a transfer happens on a rising edge where req & ready are both 1.
//   Once req is raised it stays high and addr stays stable until that transfer
//   (or a redirect / stall decided by the master's state, never by ready).
//
//   Signals
//     req    master -> slave  request valid
//     addr   master -> slave  request address
//     ready  slave  -> master slave accepts the request this cycle
// ---------------------------------------------------------------------------
interface pc_fetch_seq_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;

    modport master (output req, output addr, input ready);
    modport slave  (input req, input addr, output ready);
endinterface

// File: rtl/pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq
//   Fetch-stage sequencer owning the program counter. Issues one instruction
//   memory request at a time, steps the PC by PC_INC per accepted fetch,
//   freezes on stall and jumps on redirect (redirect has top priority).
//
//   Ports
//     clk_i             clock, rising edge
//     rst_i             asynchronous reset, active-low
//     stall_i           downstream stall, freezes fetch while 1
//     redirect_valid_i  branch/jump taken this cycle
//     redirect_addr_i   redirect target
//     imem              request channel (master side: req/addr out, ready in)
//     pc_o              current program counter
//     inst_valid_o      one-cycle pulse: a fetch completed at inst_addr_o
//     inst_addr_o       address of the completed fetch
//     fetch_cnt_o       completed (non-squashed) fetches, saturating
//     state_o           current FSM state (debug visibility)
//
//   All outputs come from registers or from the state register alone, so no
//   input reaches an output combinationally.
// ---------------------------------------------------------------------------
module pc_fetch_seq #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] PC_INC       = {{(ADDR_W-1){1'b0}}, 1'b1}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    pc_fetch_seq_if.master    imem,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [15:0]       fetch_cnt_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_q;
    logic              handshake;
    logic              accept;

    // Request is decoded from state only; address is always the live PC.
    assign imem.req  = (state == ST_REQ);
    assign imem.addr = pc_q;
    assign pc_o      = pc_q;
    assign state_o   = state;

    assign handshake = imem.req & imem.ready;
    // A redirect in the same cycle squashes the transfer.
    assign accept    = handshake & ~redirect_valid_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid_i) begin
            state_next = ST_REQ;
        end else begin
            case (state)
                ST_IDLE:  state_next = ST_REQ;
                ST_REQ:   if (stall_i) state_next = ST_STALL;
                ST_STALL: if (!stall_i) state_next = ST_REQ;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_VECTOR;
            inst_valid_o <= 1'b0;
            inst_addr_o  <= '0;
            fetch_cnt_o  <= '0;
        end else begin
            inst_valid_o <= accept;
            if (redirect_valid_i) begin
                pc_q <= redirect_addr_i;
            end else if (accept) begin
                pc_q <= pc_q + PC_INC;
            end
            if (accept) begin
                inst_addr_o <= pc_q;
                if (fetch_cnt_o != 16'hFFFF) begin
                    fetch_cnt_o <= fetch_cnt_o + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
module tb_pc_fetch_seq;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         stall_i;
  logic         redirect_valid_i;
  logic [W-1:0] redirect_addr_i;
  logic [W-1:0] pc_o;
  logic         inst_valid_o;
  logic [W-1:0] inst_addr_o;
  logic [15:0]  fetch_cnt_o;
  logic [1:0]   state_o;

  pc_fetch_seq_if #(.ADDR_W(W)) imem ();

  always #5 clk_i = ~clk_i;

  pc_fetch_seq #(.ADDR_W(W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_addr_i  (redirect_addr_i),
    .imem             (imem.master),
    .pc_o             (pc_o),
    .inst_valid_o     (inst_valid_o),
    .inst_addr_o      (inst_addr_o),
    .fetch_cnt_o      (fetch_cnt_o),
    .state_o          (state_o)
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [W-1:0] b16(input logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  // ---------------- reference model ----------------
  // The request line is a function of history: nothing in the first cycle
  // after reset, always in the second, afterwards requesting iff the previous
  // edge saw a redirect or no stall.
  logic         m_req;
  logic         m_first;
  logic         m_valid;
  logic [W-1:0] m_pc;
  logic [W-1:0] m_iaddr;
  logic [W-1:0] m_cnt;

  task automatic model_reset();
    m_req   = 1'b0;
    m_first = 1'b1;
    m_valid = 1'b0;
    m_pc    = 16'h0000;
    m_iaddr = 16'h0000;
    m_cnt   = 16'h0000;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic hs;
    hs      = m_req && imem.ready;
    m_valid = 1'b0;
    if (redirect_valid_i) begin
      m_pc = redirect_addr_i;
    end else if (hs) begin
      m_valid = 1'b1;
      m_iaddr = m_pc;
      exp_q.push_back(m_pc);
      m_pc = m_pc + 16'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    m_req   = m_first || redirect_valid_i || !stall_i;
    m_first = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("req", b16(imem.req), b16(m_req));
    if (m_req) check_eq("addr", imem.addr, m_pc);
    check_eq("pc", pc_o, m_pc);
    check_eq("valid", b16(inst_valid_o), b16(m_valid));
    if (m_valid) check_eq("inst_addr", inst_addr_o, m_iaddr);
    check_eq("cnt", fetch_cnt_o, m_cnt);
    if (inst_valid_o) begin
      if (exp_q.size() > 0) check_eq("sb_addr", inst_addr_o, exp_q.pop_front());
      else check_eq("sb_unexpected", b16(inst_valid_o), 16'h0000);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are compared there too.
  task automatic step(input logic s, input logic r, input logic [W-1:0] ra, input logic rdy);
    stall_i          = s;
    redirect_valid_i = r;
    redirect_addr_i  = ra;
    imem.ready       = rdy;
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic do_reset();
    rst_i            = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_addr_i  = '0;
    imem.ready       = 1'b0;
    repeat (2) @(negedge clk_i);
    model_reset();
    compare_all();
    check_eq("rst_iaddr", inst_addr_o, 16'h0000);
    rst_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] saved_cnt;

  initial begin
    do_reset();

    // Reset release with memory always ready: 0,1,2,3... back to back.
    step(0, 0, 0, 1);
    check_eq("t1_first_req", b16(imem.req), 16'h0001);
    check_eq("t1_first_addr", imem.addr, 16'h0000);
    repeat (5) step(0, 0, 0, 1);
    check_eq("t1_iaddr", inst_addr_o, 16'h0004);

    // Memory not ready for 3 cycles at pc 5.
    step(0, 1, 16'h0005, 0);
    repeat (3) step(0, 0, 0, 0);
    check_eq("t2_hold_addr", imem.addr, 16'h0005);
    step(0, 0, 0, 1);
    check_eq("t2_iaddr", inst_addr_o, 16'h0005);
    check_eq("t2_pc", pc_o, 16'h0006);

    // Stall for 4 cycles at pc 8; the handshake on the stall edge counts.
    step(0, 1, 16'h0008, 0);
    saved_cnt = m_cnt;
    repeat (4) step(1, 0, 0, 1);
    check_eq("t3_req_off", b16(imem.req), 16'h0000);
    check_eq("t3_pc", pc_o, 16'h0009);
    check_eq("t3_cnt", fetch_cnt_o, saved_cnt + 16'd1);
    step(0, 0, 0, 1);
    check_eq("t3_resume_req", b16(imem.req), 16'h0001);
    check_eq("t3_resume_addr", imem.addr, 16'h0009);

    // Redirect squashes a same-cycle handshake at pc 3.
    step(0, 1, 16'h0003, 0);
    saved_cnt = m_cnt;
    step(0, 1, 16'h0040, 1);
    check_eq("t4_no_valid", b16(inst_valid_o), 16'h0000);
    check_eq("t4_addr", imem.addr, 16'h0040);
    check_eq("t4_cnt", fetch_cnt_o, saved_cnt);

    // Wrap-around at 0xFFFF.
    step(0, 1, 16'hFFFF, 0);
    step(0, 0, 0, 1);
    check_eq("t5_pc", pc_o, 16'h0000);
    check_eq("t5_iaddr", inst_addr_o, 16'hFFFF);

    // Asynchronous reset mid-request at pc 0x12.
    step(0, 1, 16'h0012, 0);
    step(0, 0, 0, 0);
    #2 rst_i = 1'b0;
    #1;
    check_eq("t6_req", b16(imem.req), 16'h0000);
    check_eq("t6_pc", pc_o, 16'h0000);
    check_eq("t6_cnt", fetch_cnt_o, 16'h0000);
    check_eq("t6_valid", b16(inst_valid_o), 16'h0000);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           W'($urandom_range(0, 65535)),
           $urandom_range(0, 3) != 0);
    end
    check_eq("rand_drain", W'(exp_q.size()), 16'h0000);

    // Counter saturation after 65535+ fetches.
    do_reset();
    for (int i = 0; i < 65540; i++) step(0, 0, 0, 1);
    check_eq("sat_cnt", fetch_cnt_o, 16'hFFFF);
    check_eq("final_drain", W'(exp_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
